counter_sched: RTL and testbench
================================

# counter_sched

Timer scheduler that sequences a `counter` instance (parameter `BW`) into a programmable-period periodic or one-shot timer. It drives the counter's synchronous reset and reads back its count. It raises a one-cycle `tick_o` at every period boundary and keeps a wrapping tick tally. It sits between a software-facing configuration port and the free-running `counter` datapath. The counter shares `clk_i`/`nrst_i` with this block and counts up by one every cycle unless its `nrstSync_i` is low.

## Interface
- `BW`, 4, width of the counter, the period register and the tick tally
- `clk_i` in 1: the only clock; every flop is on its rising edge
- `nrst_i` in 1: reset, asynchronous and active-low; also wired to the counter's `nrst_i`
- `cfgValid_i` in 1: configuration offered
- `cfgReady_o` out 1: configuration accepted this cycle if `cfgValid_i`=1
- `period_i` in BW: period in cycles; 0 is illegal
- `oneshot_i` in 1: 1 = one-shot, 0 = periodic; latched with `period_i`
- `start_i` in 1: start request, level-sampled
- `stop_i` in 1: stop request, level-sampled
- `count_i` in BW: counter `count_o`
- `cntNrstSync_o` out 1: to counter `nrstSync_i`; low = clear counter
- `busy_o` out 1: timer running
- `tick_o` out 1: one-cycle pulse per elapsed period
- `ticks_o` out BW: number of ticks since last start, wrapping
- `irq_o` out 1: sticky interrupt (only with macro)
- `irqClr_i` in 1: clears `irq_o` (only with macro)

## Operation
- States: IDLE and RUN.
  - IDLE→RUN on `start_i`=1, `stop_i`=0 and period register ≠ 0.
  - RUN→IDLE on `stop_i`, or on terminal count in one-shot mode.
- Configuration: `cfgReady_o` = (state==IDLE), combinational. A handshake (`cfgValid_i`&&`cfgReady_o`) latches `period_i` and `oneshot_i` at the edge. `cfgValid_i` in RUN is held off and not lost.
- A start in the same cycle as a config handshake uses the old period register.
- Starting with period register = 0 is ignored; the block stays IDLE.
- Terminal count: state==RUN && `count_i` == period−1, computed in BW bits.
- `cntNrstSync_o` = (state==RUN) && !terminal, combinational. The counter is therefore held at 0 in IDLE and restarts at 0 after terminal. This gives a period of exactly P cycles, including P=1, where the counter stays at 0 and a tick occurs every cycle. P = 2^BW cannot be expressed; the maximum is 2^BW−1.
- Terminal count in RUN with `stop_i`=0:
  - `tick_o`=1 next cycle.
  - `ticks_o` increments, wrapping 2^BW−1→0.
  - In one-shot mode the state goes to IDLE at the same edge.
- `stop_i` wins over a terminal count in the same cycle: no tick, no tally increment.
- `stop_i` and `start_i` together in IDLE: stay IDLE.
- `start_i` in RUN is ignored.
- Start (IDLE→RUN) clears `ticks_o` to 0.

## Timing
- Reset values:
  - Registers: state IDLE, period register 0, oneshot 0.
  - Outputs: `cntNrstSync_o`=0, `busy_o`=0, `tick_o`=0, `ticks_o`=0, `irq_o`=0, `cfgReady_o`=1.
- `nrst_i` low mid-run forces all of the above immediately, without waiting for a clock edge. The configuration is lost.
- Start sampled at edge k:
  - `busy_o`=1 from k. `busy_o` is registered and equals state==RUN.
  - `count_i`=0 in the first RUN cycle.
  - The first terminal count is in cycle k+P−1 after the edge; `tick_o` is high in the cycle after edge k+P.
  - Subsequent ticks follow every P cycles.
- `tick_o` and `ticks_o` are registered: 1-cycle latency from terminal count.
- One-shot: `busy_o` falls at the same edge at which `tick_o` rises.
- Stop sampled at edge s: `busy_o`=0 and `cntNrstSync_o`=0 from s. `count_i` reads 0 after edge s+1.

## Configuration
- Macro `COUNTER_SCHED_IRQ_EN`.
- Defined:
  - `irq_o` is a flop set by every `tick_o` pulse (same edge that makes `tick_o`=1).
  - `irq_o` is cleared by `irqClr_i`; set wins over a simultaneous clear.
  - `irq_o` survives stop and start; it is reset only by `nrst_i` or `irqClr_i`.
- Undefined: `irq_o` tied to 0, `irqClr_i` ignored. The ports remain present.

## Test plan
- Reset, then configure P=5 periodic, then start → `busy_o`=1; `count_i` cycles 0..4. `tick_o` pulses every 5 cycles, first in the 6th cycle after the start edge. `ticks_o` reads 1, 2, 3.
- P=3 one-shot → exactly one `tick_o`; `busy_o` drops at the same edge; `ticks_o`=1; counter held at 0 afterwards. A further `start_i` gives one more tick.
- P=1 periodic for 8 cycles, then `stop_i` asserted in a terminal cycle → `tick_o` high every cycle, no tick after the stop. `ticks_o`=8 with BW=4.
  - Then run 20 ticks → `ticks_o` wraps to 4.
- Illegal and held-off inputs:
  - Start with period 0 → `busy_o` stays 0.
  - `cfgValid_i` during RUN → `cfgReady_o`=0; the period changes only after stop.
  - Start and stop together in IDLE → stays IDLE.
- `nrst_i` pulsed low mid-period with P=7 → all outputs reach reset values without a clock edge; the counter is at 0; the period register reads back 0, so a start is ignored.
- With `COUNTER_SCHED_IRQ_EN` defined:
  - `irq_o` sets on the first tick and stays set across stop.
  - `irqClr_i` clears it.
  - `irqClr_i` coincident with a tick leaves `irq_o`=1.

Source files
------------

// File: rtl/counter_sched.sv
// counter_sched: programmable-period periodic / one-shot timer scheduler.
// Drives the synchronous clear of an external up-counter (count_i / cntNrstSync_o)
// and produces a one-cycle tick per elapsed period plus a wrapping tick tally.
// Optional sticky interrupt enabled by defining COUNTER_SCHED_IRQ_EN; without it
// irq_o is tied low and irqClr_i is ignored (ports stay present).
//
// Configuration handshake: cfgReady_o is high whenever the FSM is IDLE; a
// transfer happens on a rising edge where cfgValid_i && cfgReady_o, latching
// period_i and oneshot_i. While RUN the request is simply held off (ready low)
// and completes once the timer is back in IDLE.
//
// FSM state is observable on busy_o, which is the registered state (RUN = 1).
module counter_sched #(
  parameter int BW = 4
) (
  input  logic          clk_i,
  input  logic          nrst_i,
  input  logic          cfgValid_i,
  output logic          cfgReady_o,
  input  logic [BW-1:0] period_i,
  input  logic          oneshot_i,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic [BW-1:0] count_i,
  output logic          cntNrstSync_o,
  output logic          busy_o,
  output logic          tick_o,
  output logic [BW-1:0] ticks_o,
  output logic          irq_o,
  input  logic          irqClr_i
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [BW-1:0] ONE = {{(BW-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [BW-1:0] period_q, period_d;
  logic          oneshot_q, oneshot_d;
  logic [BW-1:0] ticks_q, ticks_d;
  logic          tick_q, tick_d;
  logic          terminal;
  logic          cfg_fire;

  // Terminal count: last cycle of the period, compared in BW bits.
  assign terminal      = (state_q == RUN) && (count_i == (period_q - ONE));
  // Counter runs only in RUN and is cleared at terminal so each period is P cycles.
  assign cntNrstSync_o = (state_q == RUN) && !terminal;
  assign cfgReady_o    = (state_q == IDLE);
  assign busy_o        = (state_q == RUN);
  assign tick_o        = tick_q;
  assign ticks_o       = ticks_q;

  // Next-state, configuration latch and tick/tally computation.
  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    oneshot_d = oneshot_q;
    ticks_d   = ticks_q;
    tick_d    = 1'b0;
    cfg_fire  = cfgValid_i && (state_q == IDLE);

    if (cfg_fire) begin
      period_d  = period_i;
      oneshot_d = oneshot_i;
    end

    case (state_q)
      IDLE: begin
        // Start legality uses the period register as it was before this edge.
        if (start_i && !stop_i && (period_q != '0)) begin
          state_d = RUN;
          ticks_d = '0;
        end
      end
      RUN: begin
        if (stop_i) begin
          state_d = IDLE;
        end else if (terminal) begin
          tick_d  = 1'b1;
          ticks_d = ticks_q + ONE;
          if (oneshot_q) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, asynchronously cleared by nrst_i.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q   <= IDLE;
      period_q  <= '0;
      oneshot_q <= 1'b0;
      ticks_q   <= '0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      oneshot_q <= oneshot_d;
      ticks_q   <= ticks_d;
      tick_q    <= tick_d;
    end
  end

`ifdef COUNTER_SCHED_IRQ_EN
  logic irq_q, irq_d;

  // Sticky interrupt: set by each tick (set wins), cleared by irqClr_i.
  always_comb begin
    irq_d = irq_q;
    if (tick_d) begin
      irq_d = 1'b1;
    end else if (irqClr_i) begin
      irq_d = 1'b0;
    end
  end

  // Interrupt flop; survives stop/start, cleared only by reset or irqClr_i.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_o = irq_q;
`else
  logic unused_irq_clr;
  assign unused_irq_clr = irqClr_i;
  assign irq_o          = 1'b0;
`endif

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: table-driven cycle vectors with a scoreboard queue,
// a behavioural model of the external up-counter, and a hand-written
// asynchronous-reset sequence. Define COUNTER_SCHED_IRQ_EN to check irq_o.
module tb_counter_sched;

  localparam int BW = 4;
`ifdef COUNTER_SCHED_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  // Packed observation: busy, tick, ticks[3:0], count[3:0], ready, sync, irq
  localparam int W = 13;

  typedef struct packed {
    logic          start;
    logic          stop;
    logic          cfgv;
    logic [BW-1:0] per;
    logic          os;
    logic          clr;
    logic [W-1:0]  exp;
  } vec_t;

  logic          clk;
  logic          nrst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [BW-1:0] period;
  logic          oneshot;
  logic          start;
  logic          stop;
  logic [BW-1:0] count;
  logic          cnt_sync;
  logic          busy;
  logic          tick;
  logic [BW-1:0] ticks;
  logic          irq;
  logic          irq_clr;

  vec_t         tbl[$];
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;

  counter_sched #(.BW(BW)) dut (
    .clk_i         (clk),
    .nrst_i        (nrst),
    .cfgValid_i    (cfg_valid),
    .cfgReady_o    (cfg_ready),
    .period_i      (period),
    .oneshot_i     (oneshot),
    .start_i       (start),
    .stop_i        (stop),
    .count_i       (count),
    .cntNrstSync_o (cnt_sync),
    .busy_o        (busy),
    .tick_o        (tick),
    .ticks_o       (ticks),
    .irq_o         (irq),
    .irqClr_i      (irq_clr)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External counter model: async reset, sync clear when nrstSync low, else +1.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) count <= '0;
    else if (!cnt_sync) count <= '0;
    else count <= count + 1'b1;
  end

  function automatic logic [W-1:0] mk(input logic bz, input logic tk, input logic [BW-1:0] tks,
                                      input logic [BW-1:0] cnt, input logic sy, input logic iq);
    return {bz, tk, tks, cnt, ~bz, sy, iq & IRQ_EN};
  endfunction

  function automatic logic [W-1:0] observe();
    return {busy, tick, ticks, count, cfg_ready, cnt_sync, irq};
  endfunction

  task automatic add(input logic st, input logic sp, input logic cv, input logic [BW-1:0] pr,
                     input logic os, input logic cl, input logic bz, input logic tk,
                     input logic [BW-1:0] tks, input logic [BW-1:0] cnt, input logic sy,
                     input logic iq);
    vec_t v;
    v.start = st; v.stop = sp; v.cfgv = cv; v.per = pr; v.os = os; v.clr = cl;
    v.exp   = mk(bz, tk, tks, cnt, sy, iq);
    tbl.push_back(v);
  endtask

  task automatic compare(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got={busy,tick,ticks,count,rdy,sync,irq}=%b expected=%b", name, got, exp);
    end
  endtask

  // Drive one vector at negedge, queue its expectation, compare after the edge.
  task automatic step(input vec_t v, input string name);
    logic [W-1:0] e;
    @(negedge clk);
    start = v.start; stop = v.stop; cfg_valid = v.cfgv;
    period = v.per; oneshot = v.os; irq_clr = v.clr;
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    compare(name, observe(), e);
  endtask

  initial begin
    vec_t v;
    start = 0; stop = 0; cfg_valid = 0; period = '0; oneshot = 0; irq_clr = 0;
    nrst = 1'b1;
    #1 nrst = 1'b0;

    // ---- vector table ----
    // P=5 periodic: configure, start, three periods, stop, clear irq.
    add(0,0,1,5,0,0, 0,0,0,0,0,0);
    add(1,0,0,0,0,0, 1,0,0,0,1,0);
    for (int rep = 0; rep < 3; rep++) begin
      for (int c = 1; c <= 4; c++)
        add(0,0,0,0,0,0, 1,0,4'(rep),4'(c),(c != 4),(rep > 0));
      add(0,0,0,0,0,0, 1,1,4'(rep+1),0,1,1);
    end
    add(0,1,0,0,0,0, 0,0,3,1,0,1);
    add(0,0,0,0,0,0, 0,0,3,0,0,1);
    add(0,0,0,0,0,1, 0,0,3,0,0,0);
    // P=3 one-shot, twice; second run has irqClr coincident with the tick.
    add(0,0,1,3,1,0, 0,0,3,0,0,0);
    add(1,0,0,0,0,0, 1,0,0,0,1,0);
    add(0,0,0,0,0,0, 1,0,0,1,1,0);
    add(0,0,0,0,0,0, 1,0,0,2,0,0);
    add(0,0,0,0,0,0, 0,1,1,0,0,1);
    add(0,0,0,0,0,0, 0,0,1,0,0,1);
    add(1,0,0,0,0,1, 1,0,0,0,1,0);
    add(0,0,0,0,0,0, 1,0,0,1,1,0);
    add(0,0,0,0,0,0, 1,0,0,2,0,0);
    add(0,0,0,0,0,1, 0,1,1,0,0,1);
    add(0,0,0,0,0,1, 0,0,1,0,0,0);
    // P=1 periodic: 8 ticks, stop in a terminal cycle, then 20 ticks (wrap to 4).
    add(0,0,1,1,0,0, 0,0,1,0,0,0);
    add(1,0,0,0,0,0, 1,0,0,0,0,0);
    for (int n = 1; n <= 8; n++) add(0,0,0,0,0,0, 1,1,4'(n),0,0,1);
    add(0,1,0,0,0,0, 0,0,8,0,0,1);
    add(0,0,0,0,0,0, 0,0,8,0,0,1);
    add(1,0,0,0,0,0, 1,0,0,0,0,1);
    for (int n = 1; n <= 20; n++) add(0,0,0,0,0,0, 1,1,4'(n % 16),0,0,1);
    add(0,1,0,0,0,0, 0,0,4,0,0,1);
    add(0,0,0,0,0,1, 0,0,4,0,0,0);
    // Illegal / held-off: period 0, start with handshake, start+stop, cfg in RUN.
    add(0,0,1,0,0,0, 0,0,4,0,0,0);
    add(1,0,1,4,0,0, 0,0,4,0,0,0);
    add(1,1,0,0,0,0, 0,0,4,0,0,0);
    add(1,0,0,0,0,0, 1,0,0,0,1,0);
    add(0,0,1,2,0,0, 1,0,0,1,1,0);
    add(0,0,1,2,0,0, 1,0,0,2,1,0);
    add(0,0,1,2,0,0, 1,0,0,3,0,0);
    add(1,0,1,2,0,0, 1,1,1,0,1,1);
    add(1,0,1,2,0,0, 1,0,1,1,1,1);
    add(0,1,1,2,0,0, 0,0,1,2,0,1);
    add(0,0,1,2,0,0, 0,0,1,0,0,1);
    add(1,0,0,0,0,0, 1,0,0,0,1,1);
    add(0,0,0,0,0,0, 1,0,0,1,0,1);
    add(0,0,0,0,0,0, 1,1,1,0,1,1);
    add(0,1,0,0,0,0, 0,0,1,1,0,1);
    add(0,0,0,0,0,0, 0,0,1,0,0,1);

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1 compare("reset_state", observe(), mk(0,0,0,0,0,0));
    @(negedge clk);
    nrst = 1'b1;

    // ---- apply table ----
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

    // ---- asynchronous reset mid-period with P=7 ----
    v = '0; v.cfgv = 1; v.per = 7; v.exp = mk(0,0,1,0,0,1);
    step(v, "p7_cfg");
    v = '0; v.start = 1; v.exp = mk(1,0,0,0,1,1);
    step(v, "p7_start");
    for (int c = 1; c <= 3; c++) begin
      v = '0; v.exp = mk(1,0,0,4'(c),1,1);
      step(v, $sformatf("p7_run%0d", c));
    end
    @(negedge clk);
    #2 nrst = 1'b0;
    #1 compare("async_reset", observe(), mk(0,0,0,0,0,0));
    @(negedge clk);
    nrst = 1'b1;
    v = '0; v.start = 1; v.exp = mk(0,0,0,0,0,0);
    step(v, "start_after_reset");
    v = '0; v.exp = mk(0,0,0,0,0,0);
    step(v, "idle_after_reset");

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
